// File: rtl/lab01_toggle_gen.sv
// Multi-channel programmable square-wave toggle generator; optional feature macro LAB01_TOGGLE_SYNC_EN adds i_sync phase reset.
// Latency: o_y/o_wrap are registered, one clock from any input; no combinational input-to-output path.
// Backpressure: none; dropping i_en[ch] stalls that channel's count in place without losing phase.
module lab01_toggle_gen #(
    parameter int CHANNELS   = 4,
    parameter int CNT_W      = 8,
    parameter int PERIOD_RST = 0,
    localparam int SEL_W     = (CHANNELS > 1) ? $clog2(CHANNELS) : 1
) (
    input  logic                i_clk,
    input  logic                i_rst_n,
    input  logic [CHANNELS-1:0] i_en,
    input  logic                i_load,
    input  logic [SEL_W-1:0]    i_ch_sel,
    input  logic [CNT_W-1:0]    i_period,
`ifdef LAB01_TOGGLE_SYNC_EN
    input  logic                i_sync,
`endif
    output logic [CHANNELS-1:0] o_y,
    output logic [CHANNELS-1:0] o_wrap
);

    localparam logic [CNT_W-1:0] PERIOD_INIT = CNT_W'(PERIOD_RST);

    logic [CNT_W-1:0]    period_q [CHANNELS];
    logic [CNT_W-1:0]    cnt_q    [CHANNELS];
    logic [CHANNELS-1:0] y_q;
    logic [CHANNELS-1:0] wrap_q;
    logic [CHANNELS-1:0] load_hit;
    logic                sync_clr;

`ifdef LAB01_TOGGLE_SYNC_EN
    assign sync_clr = i_sync;
`else
    assign sync_clr = 1'b0;
`endif

    // An out-of-range i_ch_sel matches no channel, so the write is dropped.
    always_comb begin
        load_hit = '0;
        for (int ch = 0; ch < CHANNELS; ch++) begin
            load_hit[ch] = i_load && (i_ch_sel == SEL_W'(ch));
        end
    end

    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            for (int ch = 0; ch < CHANNELS; ch++) begin
                period_q[ch] <= PERIOD_INIT;
                cnt_q[ch]    <= '0;
            end
            y_q    <= '0;
            wrap_q <= '0;
        end else if (sync_clr) begin
            for (int ch = 0; ch < CHANNELS; ch++) begin
                cnt_q[ch] <= '0;
            end
            y_q    <= '0;
            wrap_q <= '0;
        end else begin
            for (int ch = 0; ch < CHANNELS; ch++) begin
                if (load_hit[ch]) begin
                    // A load wins over a wrap in the same cycle: the toggle is skipped.
                    period_q[ch] <= i_period;
                    cnt_q[ch]    <= '0;
                    wrap_q[ch]   <= 1'b0;
                end else if (!i_en[ch]) begin
                    wrap_q[ch]   <= 1'b0;
                end else if (cnt_q[ch] == period_q[ch]) begin
                    cnt_q[ch]    <= '0;
                    y_q[ch]      <= ~y_q[ch];
                    wrap_q[ch]   <= 1'b1;
                end else begin
                    cnt_q[ch]    <= cnt_q[ch] + 1'b1;
                    wrap_q[ch]   <= 1'b0;
                end
            end
        end
    end

    assign o_y    = y_q;
    assign o_wrap = wrap_q;

endmodule

// File: tb/tb_lab01_toggle_gen.sv
// Bench for lab01_toggle_gen with CHANNELS=3 so that i_ch_sel=3 is an out-of-range write.
module tb_lab01_toggle_gen;

    logic       clk;
    logic       rst_n;
    logic [2:0] en;
    logic       load;
    logic [1:0] ch_sel;
    logic [7:0] period;
    logic       sync;
    logic [2:0] y;
    logic [2:0] wrap;

    int n_cmp  = 0;
    int n_fail = 0;

    typedef struct packed {
        logic [2:0] y;
        logic [2:0] wrap;
    } exp_t;

    exp_t exp_q[$];

    // Reference model state
    logic [7:0] m_per [3];
    logic [7:0] m_cnt [3];
    logic [2:0] m_y;
    logic [2:0] m_wrap;

    lab01_toggle_gen #(.CHANNELS(3), .CNT_W(8), .PERIOD_RST(0)) dut (
        .i_clk    (clk),
        .i_rst_n  (rst_n),
        .i_en     (en),
        .i_load   (load),
        .i_ch_sel (ch_sel),
        .i_period (period),
`ifdef LAB01_TOGGLE_SYNC_EN
        .i_sync   (sync),
`endif
        .o_y      (y),
        .o_wrap   (wrap)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Drive one clock of stimulus, advance the model, and score the DUT output.
    task automatic cyc(input logic rst_v, input logic [2:0] en_v, input logic ld_v,
                       input logic [1:0] sel_v, input logic [7:0] per_v);
        exp_t e;
        rst_n  = rst_v;
        en     = en_v;
        load   = ld_v;
        ch_sel = sel_v;
        period = per_v;
        if (!rst_v) begin
            for (int c = 0; c < 3; c++) begin
                m_per[c] = 8'd0;
                m_cnt[c] = 8'd0;
            end
            m_y    = 3'b000;
            m_wrap = 3'b000;
        end else if (sync) begin
            for (int c = 0; c < 3; c++) m_cnt[c] = 8'd0;
            m_y    = 3'b000;
            m_wrap = 3'b000;
        end else begin
            for (int c = 0; c < 3; c++) begin
                if (ld_v && (sel_v == c)) begin
                    m_per[c]  = per_v;
                    m_cnt[c]  = 8'd0;
                    m_wrap[c] = 1'b0;
                end else if (!en_v[c]) begin
                    m_wrap[c] = 1'b0;
                end else if (m_cnt[c] == m_per[c]) begin
                    m_cnt[c]  = 8'd0;
                    m_y[c]    = ~m_y[c];
                    m_wrap[c] = 1'b1;
                end else begin
                    m_cnt[c]  = m_cnt[c] + 8'd1;
                    m_wrap[c] = 1'b0;
                end
            end
        end
        exp_q.push_back('{y: m_y, wrap: m_wrap});
        @(posedge clk);
        #1;
        e = exp_q.pop_front();
        check("sb_y", 32'(y), 32'(e.y));
        check("sb_wrap", 32'(wrap), 32'(e.wrap));
    endtask

    initial begin
        rst_n = 1'b0; en = '0; load = 1'b0; ch_sel = '0; period = '0; sync = 1'b0;

        // Reset, then all channels at period 0 toggle every clock
        cyc(0, 3'b111, 0, 0, 0);
        cyc(0, 3'b111, 0, 0, 0);
        check("rst_y", 32'(y), 32'h0);
        check("rst_wrap", 32'(wrap), 32'h0);
        cyc(1, 3'b111, 0, 0, 0);
        check("p0_y_first", 32'(y), 32'h7);
        check("p0_wrap_first", 32'(wrap), 32'h7);
        cyc(1, 3'b111, 0, 0, 0);
        check("p0_y_second", 32'(y), 32'h0);
        check("p0_wrap_second", 32'(wrap), 32'h7);
        cyc(1, 3'b111, 0, 0, 0);
        cyc(1, 3'b111, 0, 0, 0);

        // ch1 period 3, only ch1 enabled: wrap once every 4 clocks
        cyc(1, 3'b010, 1, 2'd1, 8'd3);
        check("ld1_wrap", 32'(wrap), 32'h0);
        for (int i = 0; i < 12; i++) begin
            cyc(1, 3'b010, 0, 0, 0);
            check("ch1_wrap_cadence", 32'(wrap), (i % 4 == 3) ? 32'h2 : 32'h0);
        end
        check("ch1_y_end", 32'(y), 32'h2);

        // ch2 period 2, enable dropped at cnt=1 for 5 clocks
        cyc(1, 3'b000, 1, 2'd2, 8'd2);
        cyc(1, 3'b100, 0, 0, 0);
        for (int i = 0; i < 5; i++) begin
            cyc(1, 3'b000, 0, 0, 0);
            check("ch2_frozen_y", 32'(y), 32'h2);
        end
        cyc(1, 3'b100, 0, 0, 0);
        check("ch2_resume1_y", 32'(y), 32'h2);
        check("ch2_resume1_wrap", 32'(wrap), 32'h0);
        cyc(1, 3'b100, 0, 0, 0);
        check("ch2_resume2_y", 32'(y), 32'h6);
        check("ch2_resume2_wrap", 32'(wrap), 32'h4);

        // ch2 full-range period 255: toggle on the 256th enabled clock
        cyc(1, 3'b000, 1, 2'd2, 8'd255);
        for (int i = 0; i < 256; i++) begin
            cyc(1, 3'b100, 0, 0, 0);
            check("ch2_max_wrap", 32'(wrap), (i == 255) ? 32'h4 : 32'h0);
        end
        check("ch2_max_y", 32'(y), 32'h2);

        // ch0 period 1, reload to 5 on the wrap cycle: no toggle, next after 6
        cyc(1, 3'b000, 1, 2'd0, 8'd1);
        cyc(1, 3'b001, 0, 0, 0);
        cyc(1, 3'b001, 1, 2'd0, 8'd5);
        check("reload_y", 32'(y), 32'h2);
        check("reload_wrap", 32'(wrap), 32'h0);
        for (int i = 0; i < 6; i++) begin
            cyc(1, 3'b001, 0, 0, 0);
            check("ch0_after_reload_wrap", 32'(wrap), (i == 5) ? 32'h1 : 32'h0);
        end
        check("ch0_after_reload_y", 32'(y), 32'h3);

        // Out-of-range channel select: nothing changes, ch1 keeps period 3
        cyc(1, 3'b111, 1, 2'd3, 8'd0);
        check("badsel_y", 32'(y), 32'h3);
        check("badsel_wrap", 32'(wrap), 32'h0);
        cyc(1, 3'b111, 0, 0, 0);
        cyc(1, 3'b111, 0, 0, 0);
        cyc(1, 3'b111, 0, 0, 0);
        check("badsel_ch1_wrap", 32'(wrap), 32'h2);
        check("badsel_ch1_y", 32'(y), 32'h1);

        // Mid-run reset restores PERIOD_RST
        cyc(0, 3'b111, 0, 0, 0);
        check("rerst_y", 32'(y), 32'h0);
        check("rerst_wrap", 32'(wrap), 32'h0);
        cyc(1, 3'b111, 0, 0, 0);
        check("rerst_p0_y", 32'(y), 32'h7);
        check("rerst_p0_wrap", 32'(wrap), 32'h7);
        cyc(1, 3'b111, 0, 0, 0);

`ifdef LAB01_TOGGLE_SYNC_EN
        // Sync clears phase, keeps periods, and discards a same-cycle load
        cyc(1, 3'b000, 1, 2'd0, 8'd1);
        cyc(1, 3'b000, 1, 2'd1, 8'd1);
        cyc(1, 3'b111, 0, 0, 0);
        sync = 1'b1;
        cyc(1, 3'b111, 1, 2'd2, 8'd3);
        sync = 1'b0;
        check("sync_y", 32'(y), 32'h0);
        check("sync_wrap", 32'(wrap), 32'h0);
        cyc(1, 3'b111, 0, 0, 0);
        check("sync_c1_y", 32'(y), 32'h4);
        check("sync_c1_wrap", 32'(wrap), 32'h4);
        cyc(1, 3'b111, 0, 0, 0);
        check("sync_c2_y", 32'(y), 32'h3);
        check("sync_c2_wrap", 32'(wrap), 32'h7);
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
